decode_stage: RTL and testbench

Pipelined, parametrised RV32I decode stage placed between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and reads `regs` through two combinational read ports. Results are registered in a single output pipeline register. The stage adds the following:
- writeback forwarding;
- load-use hazard stall with bubble insertion;
- flush;
- illegal-opcode flagging;
- a saturating stall counter.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/decode_stage_if.sv | 41 ++++
 rtl/imm_gen.sv | 29 ++
 rtl/decode_stage.sv | 150 +++++++++++++++
 tb/tb_decode_stage.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// RV32I opcode encodings and immediate formats shared by the decode slice.
package riscv_pkg;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master = the decode stage itself, slave = the surrounding fetch/execute logic.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;

    logic            out_valid;
    logic            out_ready;
    logic            is_store;
    logic            is_load;
    logic            is_branch;
    logic            is_jump;
    logic            is_reg;
    logic            is_alu;
    logic            is_illegal;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] branch_dest;
    logic [4:0]      dest;
    logic [2:0]      func3;
    logic            func7;

    modport master (
        input  in_valid, instr, pc, out_ready,
        output in_ready, out_valid, is_store, is_load, is_branch, is_jump, is_reg,
               is_alu, is_illegal, operand_a, operand_b, store_data, branch_dest,
               dest, func3, func7
    );

    modport slave (
        output in_valid, instr, pc, out_ready,
        input  in_ready, out_valid, is_store, is_load, is_branch, is_jump, is_reg,
               is_alu, is_illegal, operand_a, operand_b, store_data, branch_dest,
               dest, func3, func7
    );
endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended to XLEN.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Split at bit 31 so the replication count stays non-zero when XLEN == 32.
    assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: operand selection with writeback forwarding, load-use
// stall with bubble insertion, flush, illegal flagging and a stall counter.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    decode_stage_if.master     bus,
    input  logic               flush,
    output logic [4:0]         raddr1,
    output logic [4:0]         raddr2,
    input  logic [XLEN-1:0]    rdata1,
    input  logic [XLEN-1:0]    rdata2,
    input  logic               wb_en,
    input  logic [4:0]         wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign opcode = bus.instr[6:0];
    assign rs1    = bus.instr[19:15];
    assign rs2    = bus.instr[24:20];
    assign rd     = bus.instr[11:7];
    assign raddr1 = rs1;
    assign raddr2 = rs2;

    always_comb begin
        fmt = IMM_I;
        case (opcode)
            LUI, AUIPC: fmt = IMM_U;
            JAL:        fmt = IMM_J;
            BRANCH:     fmt = IMM_B;
            STORE:      fmt = IMM_S;
            default:    fmt = IMM_I;
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (bus.instr),
        .fmt   (fmt),
        .imm   (imm)
    );

    generate
        if (BYPASS) begin : g_fwd
            always_comb begin
                rs1_val = rdata1;
                if (rs1 == '0)                       rs1_val = '0;
                else if (wb_en && (wb_addr == rs1))  rs1_val = wb_data;
                rs2_val = rdata2;
                if (rs2 == '0)                       rs2_val = '0;
                else if (wb_en && (wb_addr == rs2))  rs2_val = wb_data;
            end
        end else begin : g_no_fwd
            assign rs1_val = rdata1;
            assign rs2_val = rdata2;
        end
    endgenerate

    logic            d_store, d_load, d_branch, d_jump, d_reg, d_alu, d_illegal;
    logic            use_rs1, use_rs2;
    logic [XLEN-1:0] d_a, d_b, d_sd, d_bd;
    logic [4:0]      d_dest;

    always_comb begin
        {d_store, d_load, d_branch, d_jump, d_reg, d_alu, d_illegal} = '0;
        {use_rs1, use_rs2} = '0;
        d_a    = '0;
        d_b    = '0;
        d_sd   = '0;
        d_bd   = '0;
        d_dest = '0;
        if (bus.instr[1:0] != 2'b11) begin
            d_illegal = 1'b1;
        end else begin
            case (opcode)
                LUI:    begin d_b = imm; d_dest = rd; end
                AUIPC:  begin d_a = bus.pc; d_b = imm; d_dest = rd; end
                JAL:    begin d_a = bus.pc; d_b = imm; d_bd = bus.pc + imm; d_jump = 1'b1; d_dest = rd; end
                JALR:   begin d_a = rs1_val; d_b = imm; d_jump = 1'b1; d_reg = 1'b1; use_rs1 = 1'b1; d_dest = rd; end
                BRANCH: begin d_a = rs1_val; d_b = rs2_val; d_bd = bus.pc + imm; d_branch = 1'b1;
                              use_rs1 = 1'b1; use_rs2 = 1'b1; end
                LOAD:   begin d_a = rs1_val; d_b = imm; d_load = 1'b1; use_rs1 = 1'b1; d_dest = rd; end
                STORE:  begin d_a = rs1_val; d_b = imm; d_sd = rs2_val; d_store = 1'b1;
                              use_rs1 = 1'b1; use_rs2 = 1'b1; end
                OP_IMM: begin d_a = rs1_val; d_b = imm; d_alu = 1'b1; use_rs1 = 1'b1; d_dest = rd; end
                OP:     begin d_a = rs1_val; d_b = rs2_val; d_alu = 1'b1; d_reg = 1'b1;
                              use_rs1 = 1'b1; use_rs2 = 1'b1; d_dest = rd; end
                default: d_illegal = 1'b1;
            endcase
        end
    end

    logic hazard, accept;

    assign hazard = bus.out_valid && bus.is_load && (bus.dest != '0) && bus.in_valid &&
                    ((use_rs1 && (rs1 == bus.dest)) || (use_rs2 && (rs2 == bus.dest)));
    assign bus.in_ready = flush || ((!bus.out_valid || bus.out_ready) && !hazard);
    assign accept       = bus.in_valid && bus.in_ready && !flush;

    // Hazard with out_ready drains the load and leaves a bubble; without it everything holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            {bus.is_store, bus.is_load, bus.is_branch, bus.is_jump,
             bus.is_reg, bus.is_alu, bus.is_illegal} <= '0;
            bus.operand_a   <= '0;
            bus.operand_b   <= '0;
            bus.store_data  <= '0;
            bus.branch_dest <= '0;
            bus.dest        <= '0;
            bus.func3       <= '0;
            bus.func7       <= 1'b0;
        end else if (flush) begin
            bus.out_valid   <= 1'b0;
        end else if (accept) begin
            bus.out_valid   <= 1'b1;
            {bus.is_store, bus.is_load, bus.is_branch, bus.is_jump,
             bus.is_reg, bus.is_alu, bus.is_illegal} <=
                {d_store, d_load, d_branch, d_jump, d_reg, d_alu, d_illegal};
            bus.operand_a   <= d_a;
            bus.operand_b   <= d_b;
            bus.store_data  <= d_sd;
            bus.branch_dest <= d_bd;
            bus.dest        <= d_dest;
            bus.func3       <= bus.instr[14:12];
            bus.func7       <= bus.instr[30];
        end else if (bus.out_ready) begin
            bus.out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (hazard && !flush && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one forwarding instance and one non-forwarding
// instance with a 2-bit stall counter, driven with identical stimulus.
module tb_decode_stage;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready, flush, wb_en;
    logic [31:0] instr, pc, wb_data;
    logic [4:0]  wb_addr;
    logic [4:0]  ra1_1, ra2_1, ra1_0, ra2_0;
    logic [31:0] rd1_1, rd2_1, rd1_0, rd2_0;
    logic [15:0] cnt1;
    logic [1:0]  cnt0;
    logic [6:0]  fl1;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN)) b1 ();
    decode_stage_if #(.XLEN(XLEN)) b0 ();

    assign b1.in_valid = in_valid;
    assign b1.instr    = instr;
    assign b1.pc       = pc;
    assign b1.out_ready = out_ready;
    assign b0.in_valid = in_valid;
    assign b0.instr    = instr;
    assign b0.pc       = pc;
    assign b0.out_ready = out_ready;

    assign fl1 = {b1.is_store, b1.is_load, b1.is_branch, b1.is_jump,
                  b1.is_reg, b1.is_alu, b1.is_illegal};

    // Register file contents: xN reads as the byte N repeated, x0 reads 0.
    function automatic logic [31:0] rf(input logic [4:0] a);
        return {4{{3'b000, a}}};
    endfunction

    assign rd1_1 = rf(ra1_1);
    assign rd2_1 = rf(ra2_1);
    assign rd1_0 = rf(ra1_0);
    assign rd2_0 = rf(ra2_0);

    decode_stage #(.XLEN(XLEN), .BYPASS(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .bus(b1), .flush(flush),
        .raddr1(ra1_1), .raddr2(ra2_1), .rdata1(rd1_1), .rdata2(rd2_1),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall_cnt(cnt1)
    );

    decode_stage #(.XLEN(XLEN), .BYPASS(1'b0), .CNT_W(2)) dut0 (
        .clk(clk), .reset(reset), .bus(b0), .flush(flush),
        .raddr1(ra1_0), .raddr2(ra2_0), .rdata1(rd1_0), .rdata2(rd2_0),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall_cnt(cnt0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Flag order in fl1: store load branch jump reg alu illegal
    initial begin
        reset = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b1;
        flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", b1.out_valid, 0);
        chk("rst_flags", fl1, 0);
        chk("rst_a", b1.operand_a, 0);
        chk("rst_b", b1.operand_b, 0);
        chk("rst_bd", b1.branch_dest, 0);
        chk("rst_dest", b1.dest, 0);
        chk("rst_cnt", cnt1, 0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", b1.in_ready, 1);

        // jal x3, 2000 (canonical encoding)
        in_valid = 1'b1; instr = 32'h7D0001EF; pc = 32'h100;
        cyc();
        instr = 32'h7A0801EF;
        #1;
        chk("jal_valid", b1.out_valid, 1);
        chk("jal_flags", fl1, 7'b0001000);
        chk("jal_a", b1.operand_a, 32'h100);
        chk("jal_b", b1.operand_b, 32'd2000);
        chk("jal_bd", b1.branch_dest, 32'h8D0);
        chk("jal_dest", b1.dest, 3);

        // 0x7A0801EF: J-imm also picks up instr[19:12]=0x80
        cyc();
        instr = 32'h7D0F8167; pc = 32'h180; wb_en = 1'b1; wb_addr = 5'd31; wb_data = 32'd12345;
        #1;
        chk("jalr_raddr1", ra1_1, 31);
        chk("jal2_b", b1.operand_b, 32'h000807A0);
        chk("jal2_bd", b1.branch_dest, 32'h000808A0);
        chk("jal2_dest", b1.dest, 3);

        cyc();
        wb_en = 1'b0;
        instr = 32'hABCDE0B7; pc = 32'h1C0;
        #1;
        chk("jalr_flags", fl1, 7'b0001100);
        chk("jalr_fwd_a", b1.operand_a, 32'd12345);
        chk("jalr_nofwd_a", b0.operand_a, 32'h1F1F1F1F);
        chk("jalr_b", b1.operand_b, 32'd2000);
        chk("jalr_dest", b1.dest, 2);
        chk("jalr_bd", b1.branch_dest, 0);

        cyc();
        instr = 32'hFE209CE3; pc = 32'h200;
        #1;
        chk("lui_flags", fl1, 0);
        chk("lui_a", b1.operand_a, 0);
        chk("lui_b", b1.operand_b, 32'hABCDE000);
        chk("lui_dest", b1.dest, 1);

        cyc();
        instr = 32'hFE712E23; pc = 32'h240;
        #1;
        chk("bne_flags", fl1, 7'b0010000);
        chk("bne_a", b1.operand_a, 32'h01010101);
        chk("bne_b", b1.operand_b, 32'h02020202);
        chk("bne_bd", b1.branch_dest, 32'h1F8);
        chk("bne_dest", b1.dest, 0);
        chk("bne_func3", b1.func3, 1);

        cyc();
        instr = 32'h0000A283; pc = 32'h300;
        #1;
        chk("sw_flags", fl1, 7'b1000000);
        chk("sw_a", b1.operand_a, 32'h02020202);
        chk("sw_b", b1.operand_b, 32'hFFFFFFFC);
        chk("sw_sd", b1.store_data, 32'h07070707);
        chk("sw_dest", b1.dest, 0);

        // load-use: lw x5,0(x1) then add x6,x5,x7
        cyc();
        instr = 32'h00728333; pc = 32'h304;
        #1;
        chk("lw_flags", fl1, 7'b0100000);
        chk("lw_a", b1.operand_a, 32'h01010101);
        chk("lw_dest", b1.dest, 5);
        chk("lu_in_ready", b1.in_ready, 0);
        chk("lu_raddr1", ra1_1, 5);
        chk("lu_raddr2", ra2_1, 7);
        cyc();
        chk("lu_bubble", b1.out_valid, 0);
        chk("lu_ready_after", b1.in_ready, 1);
        chk("lu_cnt1", cnt1, 1);
        chk("lu_cnt0", cnt0, 1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("add_valid", b1.out_valid, 1);
        chk("add_flags", fl1, 7'b0000110);
        chk("add_a", b1.operand_a, 32'h05050505);
        chk("add_b", b1.operand_b, 32'h07070707);
        chk("add_dest", b1.dest, 6);
        chk("add_cnt", cnt1, 1);

        // backpressure with sub x10,x11,x12 held
        in_valid = 1'b1; instr = 32'h40C58533; pc = 32'h308;
        cyc();
        out_ready = 1'b0; instr = 32'h12345537;
        #1;
        chk("sub_a", b1.operand_a, 32'h0B0B0B0B);
        chk("sub_b", b1.operand_b, 32'h0C0C0C0C);
        chk("sub_func7", b1.func7, 1);
        chk("sub_in_ready", b1.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_valid", b1.out_valid, 1);
            chk("bp_a", b1.operand_a, 32'h0B0B0B0B);
            chk("bp_dest", b1.dest, 10);
            chk("bp_in_ready", b1.in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", b1.in_ready, 1);
        cyc();
        chk("lui2_b", b1.operand_b, 32'h12345000);
        chk("lui2_dest", b1.dest, 10);
        chk("lui2_func7", b1.func7, 0);

        // flush drops the offered instruction
        flush = 1'b1; instr = 32'h00000000;
        #1;
        chk("flush_in_ready", b1.in_ready, 1);
        cyc();
        flush = 1'b0;
        #1;
        chk("flush_valid", b1.out_valid, 0);
        cyc();
        instr = 32'h00000011;
        #1;
        chk("ill_valid", b1.out_valid, 1);
        chk("ill_flags", fl1, 7'b0000001);
        chk("ill_a", b1.operand_a, 0);
        chk("ill_b", b1.operand_b, 0);
        chk("ill_dest", b1.dest, 0);
        cyc();
        instr = 32'h0000A283;
        #1;
        chk("ill_lowbits_flags", fl1, 7'b0000001);

        // flush coincident with a load-use hazard
        cyc();
        instr = 32'h00728333; flush = 1'b1;
        #1;
        chk("fh_in_ready", b1.in_ready, 1);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fh_valid", b1.out_valid, 0);
        chk("fh_cnt", cnt1, 1);

        // held hazard, counter saturation, then asynchronous reset
        in_valid = 1'b1; instr = 32'h0000A283;
        cyc();
        instr = 32'h00728333; out_ready = 1'b0;
        #1;
        chk("hold_in_ready", b1.in_ready, 0);
        repeat (4) cyc();
        chk("hold_valid", b1.out_valid, 1);
        chk("hold_dest", b1.dest, 5);
        chk("hold_cnt1", cnt1, 5);
        chk("hold_cnt0_sat", cnt0, 3);
        reset = 1'b1;
        #1;
        chk("arst_valid", b1.out_valid, 0);
        chk("arst_cnt", cnt1, 0);
        chk("arst_flags", fl1, 0);
        chk("arst_dest", b1.dest, 0);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
